// File: rtl/sl_receiver_fifo.sv
// sl_receiver_fifo: two-wire serial-line receiver with 8..32 bit words, optional
// odd parity, a first-word-fall-through FIFO, sticky error status and an irq.
module sl_receiver_fifo #(
    parameter int unsigned STATUS_WIDTH = 16,
    parameter int unsigned CONFIG_WIDTH = 16,
    parameter int unsigned STROB_POS    = 7,
    parameter int unsigned BIT_TIMEOUT  = 32,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            serial_line_zeroes_a,
    input  logic                            serial_line_ones_a,
    input  logic [CONFIG_WIDTH-1:0]         wr_config_w,
    input  logic                            wr_enable,
    output logic [CONFIG_WIDTH-1:0]         r_config_w,
    input  logic                            rd_en,
    output logic                            rd_valid,
    output logic [31:0]                     data_w,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [STATUS_WIDTH-1:0]         status_w,
    input  logic                            status_clr,
    output logic                            irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CNT_W = $clog2(STROB_POS + 2);
    localparam int unsigned TMO_W = $clog2(BIT_TIMEOUT + 2);
    localparam int unsigned CFG_W = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_STROBE, S_WAIT_END, S_CHECK, S_COMMIT, S_ERROR
    } state_t;

    typedef enum logic [1:0] {EK_WLC, EK_PEF, EK_LEF} ekind_t;

    // Synchroniser and edge-detect registers; pair is {zeroes, ones}
    logic [1:0] sync1_q, sync2_q, prev_q;
    logic       edge_c;

    // Receiver FSM state
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [5:0]         bit_cnt_q, bit_cnt_d;
    logic [32:0]        shreg_q, shreg_d;
    ekind_t             ekind_q, ekind_d;
    logic               push_c, err_evt_c, set_wlc_c, set_pef_c, set_lef_c;

    // Config: {irq_err, irq_word, bq[5:0], pce}
    logic [CFG_W-1:0]   cfg_q, cfg_d;
    logic [5:0]         word_len_c;
    logic [31:0]        mask_c, push_data_c;
    logic               busy_c, cfg_ok_c, set_cwe_c;

    // FIFO
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   count_q, count_d;
    logic               pop_c, full_c, push_ok_c, ovf_c;
    logic [31:0]        head_c;

    // Status and outputs
    logic               wlc_q, wlc_d, ovf_q, ovf_d, pef_q, pef_d, lef_q, lef_d, cwe_q, cwe_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [8:0]         err_sum_c;
    logic               rd_valid_q, rd_valid_d;
    logic [31:0]        data_q, data_d;
    logic [STATUS_WIDTH-1:0] status_q, status_d;
    logic               irq_q, irq_d;
    logic               busy_d_c;
    logic               unused_cfg_c;

    assign unused_cfg_c = ^wr_config_w[CONFIG_WIDTH-1:CFG_W];

    // Two-flop synchronisers plus one history stage for the 11 -> not-11 edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            sync1_q <= {serial_line_zeroes_a, serial_line_ones_a};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edge_c     = (prev_q == 2'b11) && (sync2_q != 2'b11);
    assign word_len_c = cfg_q[6:1] + {5'd0, cfg_q[0]};
    assign mask_c     = (cfg_q[6:1] >= 6'd32) ? 32'hFFFF_FFFF
                                              : ((32'd1 << cfg_q[6:1]) - 32'd1);
    assign push_data_c = shreg_q[31:0] & mask_c;
    assign busy_c      = (state_q != S_IDLE) || (bit_cnt_q != 6'd0);

    // Receiver FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            ekind_q   <= EK_WLC;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ekind_q   <= ekind_d;
        end
    end

    // Receiver FSM next-state: strobe sampling, word checks, commit and error handling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ekind_d   = ekind_q;
        push_c    = 1'b0;
        err_evt_c = 1'b0;
        set_wlc_c = 1'b0;
        set_pef_c = 1'b0;
        set_lef_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                tmo_d = '0;
                if (edge_c) state_d = S_STROBE;
            end
            S_STROBE: begin
                if (cnt_q == CNT_W'(STROB_POS)) begin
                    tmo_d = '0;
                    case (sync2_q)
                        2'b10, 2'b01: begin
                            if (bit_cnt_q == word_len_c) begin
                                ekind_d = EK_WLC;
                                state_d = S_ERROR;
                            end else begin
                                shreg_d[bit_cnt_q] = sync2_q[1];
                                bit_cnt_d = bit_cnt_q + 6'd1;
                                state_d   = S_WAIT_END;
                            end
                        end
                        2'b00:   state_d = S_CHECK;
                        default: begin
                            ekind_d = EK_LEF;
                            state_d = S_ERROR;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_END: begin
                if (sync2_q == 2'b11) begin
                    state_d = S_IDLE;
                end else if (tmo_q >= TMO_W'(BIT_TIMEOUT)) begin
                    ekind_d = EK_LEF;
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CHECK: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (bit_cnt_q != word_len_c) begin
                    ekind_d = EK_WLC;
                    state_d = S_ERROR;
                end else if (cfg_q[0] && !(^shreg_q)) begin
                    ekind_d = EK_PEF;
                    state_d = S_ERROR;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                tmo_d     = tmo_q + TMO_W'(1);
                push_c    = 1'b1;
                bit_cnt_d = '0;
                shreg_d   = '0;
                state_d   = S_WAIT_END;
            end
            S_ERROR: begin
                tmo_d     = '0;
                err_evt_c = 1'b1;
                set_wlc_c = (ekind_q == EK_WLC);
                set_pef_c = (ekind_q == EK_PEF);
                set_lef_c = (ekind_q == EK_LEF);
                bit_cnt_d = '0;
                shreg_d   = '0;
                state_d   = S_WAIT_END;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Config write accepted only between words and with a legal word length
    always_comb begin
        cfg_d     = cfg_q;
        cfg_ok_c  = !busy_c && (wr_config_w[6:1] >= 6'd8) && (wr_config_w[6:1] <= 6'd32);
        set_cwe_c = wr_enable && !cfg_ok_c;
        if (wr_enable && cfg_ok_c) cfg_d = wr_config_w[CFG_W-1:0];
    end

    // FIFO pointer/level next-state and fall-through head
    always_comb begin
        full_c    = (count_q == LVL_W'(FIFO_DEPTH));
        pop_c     = rd_en && (count_q != '0);
        push_ok_c = push_c && (!full_c || pop_c);
        ovf_c     = push_c && full_c && !pop_c;
        wr_ptr_d  = push_ok_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push_ok_c && !pop_c) count_d = count_q + LVL_W'(1);
        else if (!push_ok_c && pop_c) count_d = count_q - LVL_W'(1);
        head_c = (push_ok_c && (wr_ptr_q == rd_ptr_d)) ? push_data_c : mem_q[rd_ptr_d];
    end

    // Sticky flags, saturating error counter, registered status/irq values
    always_comb begin
        wlc_d = (wlc_q && !status_clr) || set_wlc_c;
        ovf_d = (ovf_q && !status_clr) || ovf_c;
        pef_d = (pef_q && !status_clr) || set_pef_c;
        lef_d = (lef_q && !status_clr) || set_lef_c;
        cwe_d = (cwe_q && !status_clr) || set_cwe_c;
        err_sum_c = {1'b0, (status_clr ? 8'd0 : err_cnt_q)} + 9'(err_evt_c) + 9'(ovf_c);
        err_cnt_d = (err_sum_c > 9'd255) ? 8'hFF : err_sum_c[7:0];
        rd_valid_d = (count_d != '0);
        data_d     = rd_valid_d ? head_c : 32'd0;
        busy_d_c   = (state_d != S_IDLE) || (bit_cnt_d != 6'd0);
        status_d       = '0;
        status_d[0]    = wlc_d;
        status_d[1]    = busy_d_c;
        status_d[2]    = rd_valid_d;
        status_d[3]    = ovf_d;
        status_d[4]    = pef_d;
        status_d[5]    = lef_d;
        status_d[6]    = (count_d == LVL_W'(FIFO_DEPTH));
        status_d[7]    = cwe_d;
        status_d[15:8] = err_cnt_d;
        irq_d = (cfg_q[7] && rd_valid_q) ||
                (cfg_q[8] && (wlc_q || ovf_q || pef_q || lef_q || cwe_q));
    end

    // FIFO storage, config and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cfg_q      <= 9'h021;
            wlc_q      <= 1'b0;
            ovf_q      <= 1'b0;
            pef_q      <= 1'b0;
            lef_q      <= 1'b0;
            cwe_q      <= 1'b0;
            err_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            data_q     <= '0;
            status_q   <= '0;
            irq_q      <= 1'b0;
        end else begin
            if (push_ok_c) mem_q[wr_ptr_q] <= push_data_c;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cfg_q      <= cfg_d;
            wlc_q      <= wlc_d;
            ovf_q      <= ovf_d;
            pef_q      <= pef_d;
            lef_q      <= lef_d;
            cwe_q      <= cwe_d;
            err_cnt_q  <= err_cnt_d;
            rd_valid_q <= rd_valid_d;
            data_q     <= data_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
        end
    end

    assign r_config_w = CONFIG_WIDTH'(cfg_q);
    assign rd_valid   = rd_valid_q;
    assign data_w     = data_q;
    assign fifo_level = count_q;
    assign status_w   = status_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_sl_receiver_fifo.sv
// Bench for sl_receiver_fifo: drives SL symbols, scoreboards received words.
module tb_sl_receiver_fifo;

    localparam int HOLD = 16;
    localparam int GAP  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        zl, ol;
    logic [15:0] wr_config_w;
    logic        wr_enable;
    logic [15:0] r_config_w;
    logic        rd_en;
    logic        rd_valid;
    logic [31:0] data_w;
    logic [2:0]  fifo_level;
    logic [15:0] status_w;
    logic        status_clr;
    logic        irq;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    sl_receiver_fifo dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .serial_line_zeroes_a (zl),
        .serial_line_ones_a   (ol),
        .wr_config_w          (wr_config_w),
        .wr_enable            (wr_enable),
        .r_config_w           (r_config_w),
        .rd_en                (rd_en),
        .rd_valid             (rd_valid),
        .data_w               (data_w),
        .fifo_level           (fifo_level),
        .status_w             (status_w),
        .status_clr           (status_clr),
        .irq                  (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One symbol: pair held for HOLD clocks, then idle for GAP clocks
    task automatic send_sym(input logic [1:0] pr, input bit do_wr);
        @(negedge clk);
        {zl, ol} = pr;
        for (int c = 0; c < HOLD; c++) begin
            @(negedge clk);
            wr_enable = do_wr && (c == 12);
        end
        wr_enable = 1'b0;
        {zl, ol} = 2'b11;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] d, input int nb, input bit pce,
                             input bit bad, input int wr_sym);
        logic par;
        par = 1'b1;
        for (int i = 0; i < nb; i++) begin
            send_sym(d[i] ? 2'b10 : 2'b01, i == wr_sym);
            par = par ^ d[i];
        end
        if (bad) par = ~par;
        if (pce) send_sym(par ? 2'b10 : 2'b01, 1'b0);
        send_sym(2'b00, 1'b0);
    endtask

    task automatic write_cfg(input logic [15:0] v);
        @(negedge clk);
        wr_config_w = v;
        wr_enable = 1'b1;
        @(negedge clk);
        wr_enable = 1'b0;
    endtask

    task automatic clear_status();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    // Pop everything the DUT holds, comparing against the scoreboard queue
    task automatic drain();
        @(negedge clk);
        for (int i = 0; i < 16 && rd_valid; i++) begin
            if (exp_q.size() == 0) check("sb_extra", 32'd1, 32'd0);
            else check("sb_data", data_w, exp_q.pop_front());
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        check("sb_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic par;
        rst_n = 1'b0; zl = 1'b1; ol = 1'b1;
        wr_config_w = '0; wr_enable = 1'b0; rd_en = 1'b0; status_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", data_w, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_status", 32'(status_w), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_cfg", 32'(r_config_w), 32'h0021);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 16'hA5C3 + odd parity, with latency check around the stop bit
        w = 32'h0000_A5C3;
        exp_q.push_back(w);
        par = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_sym(w[i] ? 2'b10 : 2'b01, 1'b0);
            par = par ^ w[i];
        end
        send_sym(par ? 2'b10 : 2'b01, 1'b0);
        @(negedge clk);
        {zl, ol} = 2'b00;
        repeat (12) @(posedge clk);
        #1 check("lat_pre", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1 check("lat_post", 32'(rd_valid), 32'd1);
        repeat (HOLD) @(negedge clk);
        {zl, ol} = 2'b11;
        repeat (GAP) @(negedge clk);
        check("word_level", 32'(fifo_level), 32'd1);
        check("word_st_valid", 32'(status_w[2]), 32'd1);
        drain();

        // Wrong parity: dropped, PEF set, counter 1, then cleared
        send_word(32'h1234, 16, 1'b1, 1'b1, -1);
        check("pef_level", 32'(fifo_level), 32'd0);
        check("pef_flag", 32'(status_w[4]), 32'd1);
        check("pef_cnt", 32'(status_w[15:8]), 32'd1);
        clear_status();
        check("pef_clr", 32'(status_w), 32'd0);

        // BQ=8: nine data bits plus parity is a word-length error
        write_cfg(16'h0011);
        check("cfg_bq8", 32'(r_config_w), 32'h0011);
        send_word(32'h1AB, 9, 1'b1, 1'b0, -1);
        check("wlc_flag", 32'(status_w[0]), 32'd1);
        check("wlc_level", 32'(fifo_level), 32'd0);
        clear_status();

        // Five words into a depth-4 FIFO without reading
        for (int k = 0; k < 5; k++) begin
            w = 32'(8'h30 + 8'(k * 17));
            if (k < 4) exp_q.push_back(w);
            send_word(w, 8, 1'b1, 1'b0, -1);
        end
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(status_w[3]), 32'd1);
        check("ovf_full", 32'(status_w[6]), 32'd1);
        check("ovf_cnt", 32'(status_w[15:8]), 32'd1);
        drain();
        clear_status();

        // Data bit followed by both lines low for 40 clocks
        @(negedge clk);
        {zl, ol} = 2'b10;
        repeat (HOLD) @(negedge clk);
        {zl, ol} = 2'b00;
        repeat (40) @(negedge clk);
        {zl, ol} = 2'b11;
        repeat (GAP) @(negedge clk);
        check("lef_flag", 32'(status_w[5]), 32'd1);
        check("lef_wrp", 32'(status_w[1]), 32'd0);
        clear_status();

        // Config write while a word is in flight is rejected
        wr_config_w = 16'h0013;
        exp_q.push_back(32'h5A);
        send_word(32'h5A, 8, 1'b1, 1'b0, 1);
        check("cwe_flag", 32'(status_w[7]), 32'd1);
        check("cwe_cfg", 32'(r_config_w), 32'h0011);
        drain();
        clear_status();

        // IRQ on word available, then reset mid-word
        write_cfg(16'h0091);
        send_word(32'h3C, 8, 1'b1, 1'b0, -1);
        check("irq_word", 32'(irq), 32'd1);
        check("irq_data", data_w, 32'h3C);
        send_sym(2'b10, 1'b0);
        send_sym(2'b01, 1'b0);
        @(negedge clk);
        {zl, ol} = 2'b10;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        {zl, ol} = 2'b11;
        @(negedge clk);
        exp_q.delete();
        check("mrst_valid", 32'(rd_valid), 32'd0);
        check("mrst_data", data_w, 32'd0);
        check("mrst_level", 32'(fifo_level), 32'd0);
        check("mrst_status", 32'(status_w), 32'd0);
        check("mrst_irq", 32'(irq), 32'd0);
        check("mrst_cfg", 32'(r_config_w), 32'h0021);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(32'hBEEF);
        send_word(32'hBEEF, 16, 1'b1, 1'b0, -1);
        check("post_rst_status", 32'(status_w & 16'hFFBB), 32'd0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
